// File: rtl/inst_fetch_resp_pkg.sv
// Shared definitions for the instruction-fetch responder: reset/chip-enable
// levels, bus widths, fetch FSM encoding and the beat address helper.
package inst_fetch_resp_pkg;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef enum logic [1:0] {
    IFS_IDLE  = 2'd0,
    IFS_FETCH = 2'd1,
    IFS_DONE  = 2'd2
  } ifs_state_t;

  // Byte address of a beat; wraps modulo 2^32 past the top of memory.
  function automatic logic [INST_ADDR_W-1:0] beat_addr(
    input logic [INST_ADDR_W-1:0] base,
    input logic [1:0]             beat
  );
    return base + {{(INST_ADDR_W-2){1'b0}}, beat};
  endfunction

endpackage

// File: rtl/inst_fetch_resp_if.sv
// Byte-wide instruction memory port: the responder (master) drives the
// address and read request, the memory (slave) returns a byte with ready.
interface inst_fetch_resp_if;
  import inst_fetch_resp_pkg::*;

  logic [INST_ADDR_W-1:0] mem_addr_o;
  logic                   mem_re_o;
  logic [7:0]             mem_data_i;
  logic                   mem_ready_i;

  modport master (
    output mem_addr_o, mem_re_o,
    input  mem_data_i, mem_ready_i
  );

  modport slave (
    input  mem_addr_o, mem_re_o,
    output mem_data_i, mem_ready_i
  );
endinterface

// File: rtl/inst_fetch_resp_hit_buf.sv
// One-entry instruction hit buffer: remembers the last completed fetch
// (address tag + word) and flags a match against the current PC.
// Only instantiated when IFETCH_HIT_BUF_EN is defined.
module ifetch_hit_buf
  import inst_fetch_resp_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [INST_ADDR_W-1:0] wr_tag,
  input  logic [INST_W-1:0]      wr_data,
  input  logic [INST_ADDR_W-1:0] rd_tag,
  output logic                   hit,
  output logic [INST_W-1:0]      rd_data
);

  logic [INST_ADDR_W-1:0] tag_q;
  logic [INST_W-1:0]      inst_q;
  logic                   hit_v;

  // Capture the entry on every unflushed completion; only reset invalidates it.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      tag_q  <= '0;
      inst_q <= '0;
      hit_v  <= 1'b0;
    end else if (wr_en) begin
      tag_q  <= wr_tag;
      inst_q <= wr_data;
      hit_v  <= 1'b1;
    end
  end

  assign hit     = hit_v && (rd_tag == tag_q);
  assign rd_data = inst_q;

endmodule

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: assembles a 32-bit instruction from four
// little-endian byte beats and stalls the PC while a fetch is in flight.
// Optional one-entry hit buffer enabled by defining IFETCH_HIT_BUF_EN.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int BEATS  = 4,
  parameter int ADDR_W = INST_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               ce_i,
  input  logic               flush_i,
  inst_fetch_resp_if.master  mem,
  output logic [INST_W-1:0]  inst_o,
  output logic               inst_valid_o,
  output logic               stallreq_o
);

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  ifs_state_t        state;
  logic [1:0]        beat;
  logic [ADDR_W-1:0] addr_q;
  logic [INST_W-1:0] buf_q;
  logic [INST_W-1:0] word_nx;
  logic              hit;
  logic [INST_W-1:0] hit_inst;

`ifdef IFETCH_HIT_BUF_EN
  ifetch_hit_buf u_hit_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   ((state == IFS_DONE) && !flush_i),
    .wr_tag  (addr_q),
    .wr_data (buf_q),
    .rd_tag  (pc_i),
    .hit     (hit),
    .rd_data (hit_inst)
  );
`else
  assign hit      = 1'b0;
  assign hit_inst = '0;
`endif

  // Merge the incoming byte into its little-endian lane of the partial word.
  always_comb begin
    word_nx = buf_q;
    word_nx[8*beat +: 8] = mem.mem_data_i;
  end

  // Fetch FSM: reset beats flush, flush beats everything else.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state  <= IFS_IDLE;
      beat   <= '0;
      addr_q <= '0;
      buf_q  <= '0;
      inst_o <= '0;
    end else if (flush_i) begin
      state <= IFS_IDLE;
      beat  <= '0;
      buf_q <= '0;
    end else begin
      case (state)
        IFS_IDLE: begin
          if (ce_i == CHIP_ENABLE) begin
            addr_q <= pc_i;
            beat   <= '0;
            if (hit) begin
              buf_q  <= hit_inst;
              inst_o <= hit_inst;
              state  <= IFS_DONE;
            end else begin
              buf_q <= '0;
              state <= IFS_FETCH;
            end
          end
        end
        IFS_FETCH: begin
          if (mem.mem_ready_i) begin
            buf_q <= word_nx;
            beat  <= beat + 2'd1;
            if (beat == LAST_BEAT) begin
              inst_o <= word_nx;
              state  <= IFS_DONE;
            end
          end
        end
        IFS_DONE: state <= IFS_IDLE;
        default:  state <= IFS_IDLE;
      endcase
    end
  end

  // Outputs decode from state; reset forces them low in the same cycle.
  assign mem.mem_re_o   = (state == IFS_FETCH) && (rst != RST_ENABLE);
  assign mem.mem_addr_o = mem.mem_re_o ? beat_addr(addr_q, beat) : '0;
  assign inst_valid_o   = (state == IFS_DONE) && !flush_i && (rst != RST_ENABLE);
  assign stallreq_o     = (ce_i == CHIP_ENABLE) && !flush_i &&
                          (state != IFS_DONE) && (rst != RST_ENABLE);

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Directed bench for inst_fetch_resp; expected words are hand-computed from
// the byte table in mem_byte(). Honours IFETCH_HIT_BUF_EN for the hit case.
module tb_inst_fetch_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic        flush_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        stallreq_o;

  int checks = 0;
  int errors = 0;

  inst_fetch_resp_if mem_if ();

  inst_fetch_resp dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .ce_i         (ce_i),
    .flush_i      (flush_i),
    .mem          (mem_if.master),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;

  // Memory image: 0..3 = addi a0,x0,1; 4..7 = zero; 8..B = addi x1,x0,1;
  // everything else = low address byte XOR A5.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0: return 8'h13;
      32'h1: return 8'h05;
      32'h2: return 8'h10;
      32'h3: return 8'h00;
      32'h4, 32'h5, 32'h6, 32'h7: return 8'h00;
      32'h8: return 8'h93;
      32'h9: return 8'h00;
      32'hA: return 8'h10;
      32'hB: return 8'h00;
      default: return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  assign mem_if.mem_data_i = mem_byte(mem_if.mem_addr_o);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full miss fetch: one IDLE cycle, four beats (optionally each preceded by
  // a not-ready cycle), then the DONE cycle carrying the word.
  task automatic fetch_chk(input string tag, input logic [31:0] pc,
                           input logic [31:0] exp, input bit alt);
    pc_i = pc; ce_i = 1'b1; flush_i = 1'b0; mem_if.mem_ready_i = 1'b0;
    #1;
    chk({tag, " idle stall"}, 32'(stallreq_o), 32'd1);
    chk({tag, " idle re"}, 32'(mem_if.mem_re_o), 32'd0);
    tick();
    for (int b = 0; b < 4; b++) begin
      if (alt) begin
        mem_if.mem_ready_i = 1'b0;
        #1;
        chk({tag, " wait addr"}, mem_if.mem_addr_o, pc + 32'(b));
        chk({tag, " wait stall"}, 32'(stallreq_o), 32'd1);
        tick();
      end
      mem_if.mem_ready_i = 1'b1;
      #1;
      chk({tag, " beat addr"}, mem_if.mem_addr_o, pc + 32'(b));
      chk({tag, " beat re"}, 32'(mem_if.mem_re_o), 32'd1);
      chk({tag, " beat valid"}, 32'(inst_valid_o), 32'd0);
      tick();
    end
    mem_if.mem_ready_i = 1'b0;
    #1;
    chk({tag, " done valid"}, 32'(inst_valid_o), 32'd1);
    chk({tag, " done inst"}, inst_o, exp);
    chk({tag, " done stall"}, 32'(stallreq_o), 32'd0);
    chk({tag, " done re"}, 32'(mem_if.mem_re_o), 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; pc_i = 32'h0; ce_i = 1'b1; flush_i = 1'b0;
    mem_if.mem_ready_i = 1'b0;
    tick();
    tick();
    chk("rst inst", inst_o, 32'h0);
    chk("rst valid", 32'(inst_valid_o), 32'd0);
    chk("rst re", 32'(mem_if.mem_re_o), 32'd0);
    chk("rst addr", mem_if.mem_addr_o, 32'h0);
    chk("rst stall", 32'(stallreq_o), 32'd0);
    rst = 1'b0; ce_i = 1'b0;
    tick();
    chk("idle ce0 stall", 32'(stallreq_o), 32'd0);
    chk("idle ce0 re", 32'(mem_if.mem_re_o), 32'd0);

    // Back-to-back ready, then wrap-around, then alternate-cycle ready.
    fetch_chk("f0", 32'h0000_0000, 32'h0010_0513, 1'b0);
    fetch_chk("wrap", 32'hFFFF_FFFE, 32'h0513_5A5B, 1'b0);
    fetch_chk("alt", 32'h0000_0000, 32'h0010_0513, 1'b1);

    // Flush on beat 2 of a fetch at 0x10; PC loads 0x100 on that edge.
    pc_i = 32'h10; ce_i = 1'b1; mem_if.mem_ready_i = 1'b0;
    tick();
    mem_if.mem_ready_i = 1'b1;
    tick();
    tick();
    flush_i = 1'b1; pc_i = 32'h100;
    #1;
    chk("flush addr", mem_if.mem_addr_o, 32'h12);
    chk("flush stall", 32'(stallreq_o), 32'd0);
    chk("flush valid", 32'(inst_valid_o), 32'd0);
    tick();
    flush_i = 1'b0; mem_if.mem_ready_i = 1'b0;
    #1;
    chk("post flush re", 32'(mem_if.mem_re_o), 32'd0);
    fetch_chk("target", 32'h0000_0100, 32'hA6A7_A4A5, 1'b0);

    // Reset in the middle of a fetch, then a clean fetch of zero bytes.
    pc_i = 32'h0; ce_i = 1'b1; mem_if.mem_ready_i = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst stall", 32'(stallreq_o), 32'd0);
    chk("midrst re", 32'(mem_if.mem_re_o), 32'd0);
    chk("midrst addr", mem_if.mem_addr_o, 32'h0);
    tick();
    pc_i = 32'h4; mem_if.mem_ready_i = 1'b0;
    #1;
    chk("midrst inst", inst_o, 32'h0);
    chk("midrst valid", 32'(inst_valid_o), 32'd0);
    tick();
    rst = 1'b0;
    fetch_chk("after rst", 32'h0000_0004, 32'h0000_0000, 1'b0);

    // Same address twice back-to-back.
    fetch_chk("hit first", 32'h0000_0008, 32'h0010_0093, 1'b0);
`ifdef IFETCH_HIT_BUF_EN
    pc_i = 32'h8; ce_i = 1'b1;
    #1;
    chk("hit idle stall", 32'(stallreq_o), 32'd1);
    tick();
    chk("hit valid", 32'(inst_valid_o), 32'd1);
    chk("hit inst", inst_o, 32'h0010_0093);
    chk("hit re", 32'(mem_if.mem_re_o), 32'd0);
    chk("hit stall", 32'(stallreq_o), 32'd0);
    tick();
`else
    fetch_chk("hit second", 32'h0000_0008, 32'h0010_0093, 1'b0);
`endif

    // Flush arriving in DONE swallows the valid pulse.
    pc_i = 32'h20; ce_i = 1'b1; mem_if.mem_ready_i = 1'b0;
    tick();
    mem_if.mem_ready_i = 1'b1;
    for (int b = 0; b < 4; b++) tick();
    mem_if.mem_ready_i = 1'b0; flush_i = 1'b1;
    #1;
    chk("done flush valid", 32'(inst_valid_o), 32'd0);
    chk("done flush stall", 32'(stallreq_o), 32'd0);
    tick();
    flush_i = 1'b0; ce_i = 1'b0;
    #1;
    chk("final valid", 32'(inst_valid_o), 32'd0);
    chk("final re", 32'(mem_if.mem_re_o), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
